mem_arbiter_rr: RTL and testbench

- Parametrised successor to the two-port I/D cache-to-memory queue.
- Arbitrates NUM_CH cache/requester channels onto one shared multi-cycle memory port (memory4c-style: enable pulse, later data_valid).
- Reads and writes both go through arbitration. Selection is round-robin or fixed priority.
- Per-channel response strobes, a busy flag, and a watchdog timeout for a memory that never returns data_valid.

---
 rtl/mem_arbiter_rr.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: arbitrates NUM_CH requester channels onto one shared
// multi-cycle memory port (enable pulse, later data_valid).
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   req_en/req_wr   per-channel request level and write flag
//   req_addr/wdata  flattened per-channel address / write data
//   rsp_valid       one-hot completion strobe (one cycle)
//   rsp_rdata       shared read data, zero unless rsp_valid is high
//   mem_*           memory port; mem_en pulses once per transaction
//   busy            high whenever a transaction is in flight
//   timeout_err     sticky read-timeout flag, cleared only by rst
module mem_arbiter_rr #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned RR_MODE     = 1,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_en,
    input  logic [NUM_CH-1:0]        req_wr,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_data_valid,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        WRITE_ACK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    grant_q, grant_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic               any_req;
    logic               found_hi, found_lo;
    logic [CH_W-1:0]    sel_hi, sel_lo, sel;
    logic               sel_wr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [CH_W-1:0]    ptr_next;
    logic [NUM_CH-1:0]  grant_onehot;

    // Channel select: round-robin is "first requester at or above rr_ptr",
    // falling back to the lowest requester, which is the wrap-around case.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!found_hi && req_en[c] && (CH_W'(c) >= rr_ptr_q)) begin
                found_hi = 1'b1;
                sel_hi   = CH_W'(c);
            end
            if (!found_lo && req_en[c]) begin
                found_lo = 1'b1;
                sel_lo   = CH_W'(c);
            end
        end
        any_req = found_lo;
        if (RR_MODE != 0) begin
            sel = found_hi ? sel_hi : sel_lo;
        end else begin
            sel = sel_lo;
        end
    end

    // Field mux for the selected channel.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == sel) begin
                sel_wr    = req_wr[c];
                sel_addr  = req_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[c*DATA_W +: DATA_W];
            end
        end
    end

    // Explicit wrap keeps the pointer legal for non-power-of-2 channel counts.
    assign ptr_next     = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
    assign grant_onehot = NUM_CH'(1) << grant_q;

    // Next-state and memory/response port logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        rsp_valid     = '0;
        rsp_rdata     = '0;

        case (state_q)
            IDLE: begin
                // Gated by rst so the memory port stays quiet while in reset.
                if (any_req && !rst) begin
                    mem_en     = 1'b1;
                    mem_wr     = sel_wr;
                    mem_addr   = sel_addr;
                    mem_wdata  = sel_wr ? sel_wdata : '0;
                    grant_d    = sel;
                    wait_cnt_d = '0;
                    state_d    = sel_wr ? WRITE_ACK : READ_WAIT;
                end
            end
            READ_WAIT: begin
                // Data valid takes priority over a coincident timeout.
                if (mem_data_valid) begin
                    rsp_valid = grant_onehot;
                    rsp_rdata = mem_rdata;
                    rr_ptr_d  = ptr_next;
                    state_d   = IDLE;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rsp_valid     = grant_onehot;
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = ptr_next;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            WRITE_ACK: begin
                rsp_valid = grant_onehot;
                rr_ptr_d  = ptr_next;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed and randomized checks of mem_arbiter_rr
// (3 channels, round-robin, 16-cycle read timeout) against a
// transaction-level reference model.
module tb_mem_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RR = 1;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_en, req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en, mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            mem_data_valid;
    logic            busy, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;   // model: channel to search from next
    bit m_err    = 1'b0;
    int ch;

    mem_arbiter_rr #(
        .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(RR), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_en(req_en), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Which channel should win, given the set of requesters.
    function automatic int pick(input logic [N-1:0] en);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (RR != 0) ? (m_ptr + k) % N : k;
            if (en[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int c, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_en[c]             = 1'b1;
        req_wr[c]             = wr;
        req_addr[c*AW +: AW]  = a;
        req_wdata[c*DW +: DW] = d;
    endtask

    task automatic raise(input int c, input bit wr);
        set_req(c, wr, AW'($urandom), DW'($urandom));
    endtask

    // Runs one transaction from grant to completion. Entered and left at a
    // drive point (1 time unit after a rising edge). Read data arrives d
    // cycles after the grant cycle; d > TO means it never arrives.
    task automatic run_txn(input int d, input logic [DW-1:0] rdata, output int gch);
        int n;
        int last;
        bit wr;
        n = 0;
        @(negedge clk);
        while (mem_en !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        check("grant_mem_en", mem_en, 1);
        gch = pick(req_en);
        if (gch < 0) gch = 0;
        wr = req_wr[gch];
        check("grant_busy", busy, 0);
        check("grant_rsp", rsp_valid, 0);
        check("grant_wr", mem_wr, wr);
        check("grant_addr", mem_addr, req_addr[gch*AW +: AW]);
        check("grant_wdata", mem_wdata, wr ? req_wdata[gch*DW +: DW] : 0);
        check("grant_err", timeout_err, m_err);
        if (wr) begin
            @(posedge clk); #1;
            mem_data_valid = 1'($urandom);
            mem_rdata      = DW'($urandom);
            @(negedge clk);
            check("wack_rsp", rsp_valid, 1 << gch);
            check("wack_mem_en", mem_en, 0);
            check("wack_busy", busy, 1);
        end else begin
            last = (d <= TO) ? d : TO;
            for (int k = 1; k <= last; k++) begin
                @(posedge clk); #1;
                mem_data_valid = (k == d);
                mem_rdata      = (k == d) ? rdata : DW'($urandom);
                @(negedge clk);
                check("rd_busy", busy, 1);
                check("rd_mem_en", mem_en, 0);
                if (k < last) begin
                    check("rd_wait_rsp", rsp_valid, 0);
                    check("rd_wait_rdata", rsp_rdata, 0);
                end else begin
                    check("rd_rsp", rsp_valid, 1 << gch);
                    check("rd_rdata", rsp_rdata, (d <= TO) ? rdata : 0);
                end
            end
            if (d > TO) m_err = 1'b1;
        end
        m_ptr = (gch + 1) % N;
        @(posedge clk); #1;
        mem_data_valid = 1'b0;
        req_en[gch]    = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        req_en         = '0;
        req_wr         = '0;
        req_addr       = '0;
        req_wdata      = '0;
        mem_rdata      = '0;
        mem_data_valid = 1'b0;
        for (int c = 0; c < N; c++) raise(c, 1'b1);

        // Reset: every output low even with requests pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", timeout_err, 0);
        @(posedge clk); #1;
        req_en = '0;
        rst    = 1'b0;
        @(negedge clk);
        check("idle_mem_en", mem_en, 0);
        check("idle_busy", busy, 0);
        @(posedge clk); #1;

        // Round-robin fairness with every channel re-requesting.
        for (int c = 0; c < N; c++) raise(c, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_txn($urandom_range(1, 5), DW'($urandom), ch);
            check("rr_order", ch, i % 3);
            if (i < 5) raise(ch, 1'b0);
        end
        req_en = '0;

        // Single read on ch1, data after 4 cycles.
        set_req(1, 1'b0, 16'h0040, 16'h0000);
        run_txn(4, 16'hBEEF, ch);
        check("single_rd_ch", ch, 1);

        // Single write on ch0.
        set_req(0, 1'b1, 16'h0010, 16'h1234);
        run_txn(1, 16'h0000, ch);
        check("single_wr_ch", ch, 0);

        // Valid on the same cycle the timeout would fire: data wins.
        raise(2, 1'b0);
        run_txn(TO, 16'hA5C3, ch);
        @(negedge clk);
        check("boundary_err", timeout_err, 0);

        // Stray data_valid while idle.
        @(posedge clk); #1;
        mem_data_valid = 1'b1;
        mem_rdata      = 16'h5A5A;
        @(negedge clk);
        check("stray_rsp", rsp_valid, 0);
        check("stray_rdata", rsp_rdata, 0);
        check("stray_busy", busy, 0);
        @(posedge clk); #1;
        mem_data_valid = 1'b0;

        // Read timeout: sticky error.
        raise(1, 1'b0);
        run_txn(100, 16'h0000, ch);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("timeout_err_sticky", timeout_err, 1);
            @(posedge clk); #1;
        end

        // Reset two cycles into a read, then a stale data_valid.
        raise(1, 1'b0);
        @(negedge clk);
        check("mid_grant_en", mem_en, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp", rsp_valid, 0);
        check("mid_rst_err", timeout_err, 0);
        check("mid_rst_mem_en", mem_en, 0);
        @(posedge clk); #1;
        req_en         = '0;
        rst            = 1'b0;
        m_ptr          = 0;
        m_err          = 1'b0;
        mem_data_valid = 1'b1;
        mem_rdata      = 16'hDEAD;
        @(negedge clk);
        check("stale_rsp", rsp_valid, 0);
        check("stale_busy", busy, 0);
        @(posedge clk); #1;
        mem_data_valid = 1'b0;
        for (int c = 0; c < N; c++) raise(c, 1'b0);
        run_txn(2, 16'h7777, ch);
        check("post_rst_ch", ch, 0);

        // Random traffic against the model.
        for (int t = 0; t < 60; t++) begin
            if (req_en == '0) begin
                repeat ($urandom_range(0, 2)) begin
                    mem_data_valid = 1'($urandom);
                    mem_rdata      = DW'($urandom);
                    @(negedge clk);
                    check("gap_rsp", rsp_valid, 0);
                    check("gap_rdata", rsp_rdata, 0);
                    check("gap_busy", busy, 0);
                    check("gap_mem_en", mem_en, 0);
                    @(posedge clk); #1;
                end
                mem_data_valid = 1'b0;
                raise($urandom_range(0, N - 1), 1'($urandom));
            end
            run_txn($urandom_range(1, 20), DW'($urandom), ch);
            for (int c = 0; c < N; c++) begin
                if (!req_en[c] && c != ch && $urandom_range(0, 1) == 1) raise(c, 1'($urandom));
            end
        end

        req_en = '0;
        @(negedge clk);
        check("final_err", timeout_err, m_err);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
